// File: rtl/posit_pd_arbiter_pkg.sv
// Shared types and helpers for arbitrating posit-decoded (pd) beat streams:
// pd field widths, arbiter state record and the round-robin pick function.
package posit_pd_arbiter_pkg;

   typedef enum logic [0:0] {
      NORMAL   = 1'b0,
      EXTENDED = 1'b1
   } pd_type_t;

   localparam int MAX_REQ = 64;
   localparam int IDX_W   = 6;

   typedef struct packed {
      logic [IDX_W-1:0] ptr;
      logic             locked;
      logic [IDX_W-1:0] owner;
   } pd_arb_state_t;

   typedef struct packed {
      logic             found;
      logic [IDX_W-1:0] idx;
   } rr_pick_t;

   // Signed scale must hold +/-((n-2) << es) plus the exponent bits.
   function automatic int scale_w(input int n, input int es);
      return $clog2((n - 1) << es) + 2;
   endfunction

   function automatic int frac_w(input int n, input int es, input pd_type_t t);
      int w;
      w = n - es - 3;
      if (w < 1) w = 1;
      if (t == EXTENDED) w = w + 2;
      return w;
   endfunction

   // sign, nar, zero, scale, fraction, guard, round, sticky
   function automatic int pd_w(input int n, input int es, input pd_type_t t);
      return 6 + scale_w(n, es) + frac_w(n, es, t);
   endfunction

   function automatic rr_pick_t rr_next(input int ptr, input logic [MAX_REQ-1:0] valid,
                                        input int n);
      rr_pick_t r;
      int       j;
      r.found = 1'b0;
      r.idx   = '0;
      j       = 0;
      for (int k = 0; k < MAX_REQ; k++) begin
         if (k < n) begin
            j = (ptr + k) % n;
            if (!r.found && valid[IDX_W'(j)]) begin
               r.found = 1'b1;
               r.idx   = IDX_W'(j);
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/posit_pd_arbiter_if.sv
// One decoded posit (pd) beat; widths follow the posit format and pd type.
interface posit_pd_arbiter_if import posit_pd_arbiter_pkg::*; #(
   parameter int       POSIT_WIDTH = 16,
   parameter int       POSIT_ES    = 1,
   parameter pd_type_t PD_TYPE     = NORMAL
);
   localparam int SCALE_W = scale_w(POSIT_WIDTH, POSIT_ES);
   localparam int FRAC_W  = frac_w(POSIT_WIDTH, POSIT_ES, PD_TYPE);

   logic                      sign;
   logic                      nar;
   logic                      zero;
   logic signed [SCALE_W-1:0] scale;
   logic        [FRAC_W-1:0]  fraction;
   logic                      guard;
   logic                      round;
   logic                      sticky;

   modport master (output sign, nar, zero, scale, fraction, guard, round, sticky);
   modport slave  (input  sign, nar, zero, scale, fraction, guard, round, sticky);

endinterface

// File: rtl/posit_pd_arbiter_rr_select.sv
// Combinational round-robin pick: first valid requester at or after ptr, with wrap.
module posit_pd_arbiter_rr_select import posit_pd_arbiter_pkg::*; #(
   parameter int NUM_REQ = 4,
   parameter int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [SRC_W-1:0]   idx,
   output logic               any
);

   rr_pick_t pick;

   always_comb begin
      pick  = rr_next(int'(ptr), MAX_REQ'(valid), NUM_REQ);
      any   = pick.found;
      idx   = pick.idx[SRC_W-1:0];
      grant = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         grant[i] = pick.found && (int'(pick.idx) == i);
      end
   end

endmodule

// File: rtl/posit_pd_arbiter.sv
// Burst-locked round-robin arbiter feeding one shared pd consumer through a
// registered output slice (one-beat latency, full throughput).
module posit_pd_arbiter import posit_pd_arbiter_pkg::*; #(
   parameter int       POSIT_WIDTH = 16,
   parameter int       POSIT_ES    = 1,
   parameter pd_type_t PD_TYPE     = NORMAL,
   parameter int       NUM_REQ     = 4,
   parameter int       SRC_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   posit_pd_arbiter_if.slave        in_pd [NUM_REQ],
   input  logic [NUM_REQ-1:0]       in_valid,
   input  logic [NUM_REQ-1:0]       in_last,
   output logic [NUM_REQ-1:0]       in_ready,
   posit_pd_arbiter_if.master       out_pd,
   output logic                     out_valid,
   output logic                     out_last,
   output logic [SRC_W-1:0]         out_src,
   input  logic                     out_ready
);

   localparam int SCALE_W = scale_w(POSIT_WIDTH, POSIT_ES);
   localparam int FRAC_W  = frac_w(POSIT_WIDTH, POSIT_ES, PD_TYPE);
   localparam int PD_W    = pd_w(POSIT_WIDTH, POSIT_ES, PD_TYPE);

   logic [PD_W-1:0] beat_v [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign beat_v[g] = {in_pd[g].sign, in_pd[g].nar, in_pd[g].zero, in_pd[g].scale,
                          in_pd[g].fraction, in_pd[g].guard, in_pd[g].round, in_pd[g].sticky};
   end

   pd_arb_state_t       state_q, state_d;
   logic                out_valid_q, out_valid_d;
   logic                out_last_q, out_last_d;
   logic [SRC_W-1:0]    out_src_q, out_src_d;
   logic [PD_W-1:0]     out_beat_q, out_beat_d;

   logic                adv;
   logic [NUM_REQ-1:0]  owner_oh;
   logic [NUM_REQ-1:0]  cand;
   logic [NUM_REQ-1:0]  grant;
   logic [SRC_W-1:0]    sel_idx;
   logic                any;
   logic [PD_W-1:0]     sel_beat;
   logic                sel_last;

   // While a burst is open only its owner may compete.
   always_comb begin
      adv      = out_ready | ~out_valid_q;
      owner_oh = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         owner_oh[i] = (int'(state_q.owner) == i);
      end
      cand = state_q.locked ? (in_valid & owner_oh) : in_valid;
   end

   posit_pd_arbiter_rr_select #(
      .NUM_REQ (NUM_REQ),
      .SRC_W   (SRC_W)
   ) u_rr_select (
      .valid (cand),
      .ptr   (state_q.ptr),
      .grant (grant),
      .idx   (sel_idx),
      .any   (any)
   );

   always_comb begin
      sel_beat = '0;
      sel_last = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_beat = beat_v[i];
            sel_last = in_last[i];
         end
      end
   end

   assign in_ready = (adv && !rst) ? grant : '0;

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_src_d   = out_src_q;
      out_beat_d  = out_beat_q;
      if (adv) begin
         out_valid_d = any;
         if (any) begin
            out_beat_d = sel_beat;
            out_last_d = sel_last;
            out_src_d  = sel_idx;
            if (sel_last) begin
               state_d.locked = 1'b0;
               state_d.ptr    = IDX_W'((int'(sel_idx) + 1) % NUM_REQ);
            end else begin
               state_d.locked = 1'b1;
               state_d.owner  = IDX_W'(sel_idx);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_src_q   <= '0;
         out_beat_q  <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_src_q   <= out_src_d;
         out_beat_q  <= out_beat_d;
      end
   end

   assign out_valid       = out_valid_q;
   assign out_last        = out_last_q;
   assign out_src         = out_src_q;
   assign out_pd.sticky   = out_beat_q[0];
   assign out_pd.round    = out_beat_q[1];
   assign out_pd.guard    = out_beat_q[2];
   assign out_pd.fraction = out_beat_q[3 +: FRAC_W];
   assign out_pd.scale    = out_beat_q[3 + FRAC_W +: SCALE_W];
   assign out_pd.zero     = out_beat_q[3 + FRAC_W + SCALE_W];
   assign out_pd.nar      = out_beat_q[4 + FRAC_W + SCALE_W];
   assign out_pd.sign     = out_beat_q[5 + FRAC_W + SCALE_W];

endmodule

// File: tb/tb_posit_pd_arbiter.sv
// Randomized scoreboard bench for posit_pd_arbiter (4 requesters) plus a
// single-requester register-slice build.
module tb_posit_pd_arbiter;
   import posit_pd_arbiter_pkg::*;

   localparam int N  = 4;
   localparam int PW = 16;
   localparam int ES = 1;
   localparam int BW = pd_w(PW, ES, NORMAL);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   posit_pd_arbiter_if #(.POSIT_WIDTH(PW), .POSIT_ES(ES), .PD_TYPE(NORMAL)) in_if [N] ();
   posit_pd_arbiter_if #(.POSIT_WIDTH(PW), .POSIT_ES(ES), .PD_TYPE(NORMAL)) out_if ();
   posit_pd_arbiter_if #(.POSIT_WIDTH(PW), .POSIT_ES(ES), .PD_TYPE(NORMAL)) in_if1 [1] ();
   posit_pd_arbiter_if #(.POSIT_WIDTH(PW), .POSIT_ES(ES), .PD_TYPE(NORMAL)) out_if1 ();

   logic [BW-1:0] drv_beat [N];
   logic [N-1:0]  in_valid, in_last, in_ready;
   logic          out_valid, out_last, out_ready;
   logic [1:0]    out_src;
   logic [BW-1:0] out_beat;

   logic [BW-1:0] drv1;
   logic [0:0]    in_valid1, in_last1, in_ready1, out_src1;
   logic          out_valid1, out_last1, out_ready1;
   logic [BW-1:0] out_beat1;

   for (genvar g = 0; g < N; g++) begin : g_drv
      assign {in_if[g].sign, in_if[g].nar, in_if[g].zero, in_if[g].scale, in_if[g].fraction,
              in_if[g].guard, in_if[g].round, in_if[g].sticky} = drv_beat[g];
   end
   assign {in_if1[0].sign, in_if1[0].nar, in_if1[0].zero, in_if1[0].scale, in_if1[0].fraction,
           in_if1[0].guard, in_if1[0].round, in_if1[0].sticky} = drv1;
   assign out_beat  = {out_if.sign, out_if.nar, out_if.zero, out_if.scale, out_if.fraction,
                       out_if.guard, out_if.round, out_if.sticky};
   assign out_beat1 = {out_if1.sign, out_if1.nar, out_if1.zero, out_if1.scale, out_if1.fraction,
                       out_if1.guard, out_if1.round, out_if1.sticky};

   posit_pd_arbiter #(.POSIT_WIDTH(PW), .POSIT_ES(ES), .PD_TYPE(NORMAL), .NUM_REQ(N)) dut (
      .clk(clk), .rst(rst), .in_pd(in_if), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready), .out_pd(out_if), .out_valid(out_valid), .out_last(out_last),
      .out_src(out_src), .out_ready(out_ready));

   posit_pd_arbiter #(.POSIT_WIDTH(PW), .POSIT_ES(ES), .PD_TYPE(NORMAL), .NUM_REQ(1)) dut1 (
      .clk(clk), .rst(rst), .in_pd(in_if1), .in_valid(in_valid1), .in_last(in_last1),
      .in_ready(in_ready1), .out_pd(out_if1), .out_valid(out_valid1), .out_last(out_last1),
      .out_src(out_src1), .out_ready(out_ready1));

   typedef struct packed { logic [BW-1:0] beat; logic last; } beat_t;
   typedef struct { int src; logic [BW-1:0] beat; logic last; } exp_t;

   beat_t pend [N][64];
   int    head [N];
   int    tail [N];
   exp_t  exp_q [$];
   int    m_ptr, m_owner;
   bit    m_locked, m_ovalid;
   int    n_checks = 0;
   int    n_pass   = 0;

   task automatic check(input string name, input bit ok, input logic [63:0] act,
                        input logic [63:0] expv);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
   endtask

   // Fresh per-requester beat lists; bursts of 1..max_len beats.
   task automatic fill(input int max_len);
      int len;
      for (int i = 0; i < N; i++) begin
         head[i] = 0;
         tail[i] = 0;
         while (tail[i] < 56) begin
            len = $urandom_range(1, max_len);
            for (int b = 0; b < len; b++) begin
               pend[i][tail[i]].beat = BW'({$urandom(), $urandom()});
               pend[i][tail[i]].last = (b == len - 1);
               tail[i]++;
            end
         end
      end
   endtask

   // One cycle: drive at posedge+1, check at negedge, advance model at posedge.
   task automatic step(input int vprob, input int rprob);
      int       sel, j;
      bit       found, adv;
      logic [N-1:0] exp_rdy;
      for (int i = 0; i < N; i++) begin
         if (head[i] < tail[i]) begin
            drv_beat[i] = pend[i][head[i]].beat;
            in_last[i]  = pend[i][head[i]].last;
            in_valid[i] = ($urandom_range(0, 99) < vprob);
         end else begin
            drv_beat[i] = BW'($urandom());
            in_last[i]  = 1'($urandom());
            in_valid[i] = 1'b0;
         end
      end
      out_ready = ($urandom_range(0, 99) < rprob);
      found = 0;
      sel   = 0;
      if (m_locked) begin
         if (in_valid[m_owner]) begin found = 1; sel = m_owner; end
      end else begin
         for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (!found && in_valid[j]) begin found = 1; sel = j; end
         end
      end
      adv     = out_ready || !m_ovalid;
      exp_rdy = (adv && found) ? (N'(1) << sel) : '0;
      @(negedge clk);
      check("in_ready", in_ready == exp_rdy, 64'(in_ready), 64'(exp_rdy));
      check("out_valid", out_valid == m_ovalid, 64'(out_valid), 64'(m_ovalid));
      @(posedge clk);
      if (adv && found) begin
         exp_q.push_back('{sel, pend[sel][head[sel]].beat, pend[sel][head[sel]].last});
         if (pend[sel][head[sel]].last) begin
            m_locked = 0;
            m_ptr    = (sel + 1) % N;
         end else begin
            m_locked = 1;
            m_owner  = sel;
         end
         head[sel]++;
      end
      if (adv) m_ovalid = found;
      #1;
   endtask

   task automatic do_reset(input int cycles);
      rst       = 1'b1;
      in_valid  = '1;
      out_ready = 1'b1;
      exp_q.delete();
      m_ptr = 0; m_owner = 0; m_locked = 0; m_ovalid = 0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         check("rst_in_ready", in_ready == '0, 64'(in_ready), 64'd0);
         if (c > 0) begin
            check("rst_out_valid", out_valid == 1'b0, 64'(out_valid), 64'd0);
            check("rst_out_src", out_src == '0, 64'(out_src), 64'd0);
            check("rst_out_last", out_last == 1'b0, 64'(out_last), 64'd0);
            check("rst_out_pd", out_beat == '0, 64'(out_beat), 64'd0);
            check("rst_out_valid1", out_valid1 == 1'b0, 64'(out_valid1), 64'd0);
         end
         @(posedge clk);
         #1;
      end
      rst      = 1'b0;
      in_valid = '0;
   endtask

   // Scoreboard monitor: a beat leaves whenever out_valid & out_ready.
   initial begin
      exp_t          e;
      bit            stalled;
      logic [BW+2:0] held;
      stalled = 0;
      held    = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stalled = 0;
         end else begin
            if (stalled)
               check("stall_hold", out_valid && ({out_src, out_last, out_beat} == held),
                     64'({out_src, out_last, out_beat}), 64'(held));
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_beat", 1'b0, 64'(out_src), 64'hffff);
               end else begin
                  e = exp_q.pop_front();
                  check("out_src", int'(out_src) == e.src, 64'(out_src), 64'(e.src));
                  check("out_pd", out_beat == e.beat, 64'(out_beat), 64'(e.beat));
                  check("out_last", out_last == e.last, 64'(out_last), 64'(e.last));
               end
            end
            stalled = out_valid && !out_ready;
            held    = {out_src, out_last, out_beat};
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [BW-1:0] b1 [8];
      in_valid = '0; in_last = '0; out_ready = 1'b0;
      for (int i = 0; i < N; i++) drv_beat[i] = '0;
      drv1 = '0; in_valid1 = '0; in_last1 = '0; out_ready1 = 1'b1;
      fill(1);
      @(posedge clk);
      #1;
      do_reset(3);

      // Single-beat bursts from everyone: plain rotation 0,1,2,3,0,...
      fill(1);
      repeat (10) step(100, 100);

      // Multi-beat bursts with random bubbles and back-pressure.
      fill(4);
      repeat (300) step(70, 70);

      // Hold the output for 5 cycles while everyone is pending.
      repeat (3) step(100, 100);
      repeat (5) step(100, 0);
      repeat (40) step(80, 80);

      // Reset in the middle of an open burst.
      fill(4);
      for (int t = 0; t < 60 && !m_locked; t++) step(100, 100);
      do_reset(2);
      fill(4);
      repeat (200) step(80, 60);
      repeat (30) step(0, 100);
      check("drain_empty", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);

      // Single-requester build: a registered pass-through.
      for (int k = 0; k < 8; k++) b1[k] = BW'({$urandom(), $urandom()});
      for (int k = 0; k <= 8; k++) begin
         if (k > 0) begin
            check("n1_out_valid", out_valid1 == 1'b1, 64'(out_valid1), 64'd1);
            check("n1_out_src", out_src1 == 1'b0, 64'(out_src1), 64'd0);
            check("n1_out_pd", out_beat1 == b1[k-1], 64'(out_beat1), 64'(b1[k-1]));
            check("n1_out_last", out_last1 == 1'((k - 1) % 2), 64'(out_last1), 64'((k - 1) % 2));
         end
         if (k < 8) begin
            drv1 = b1[k]; in_valid1 = 1'b1; in_last1 = 1'(k % 2);
         end else begin
            in_valid1 = 1'b0;
         end
         @(negedge clk);
         if (k < 8) check("n1_in_ready", in_ready1 == 1'b1, 64'(in_ready1), 64'd1);
         @(posedge clk);
         #1;
      end
      check("n1_idle", out_valid1 == 1'b0, 64'(out_valid1), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
